despread_symbol_sync: RTL and testbench
=======================================

# despread_symbol_sync

Symbol-timing controller placed directly after the Barker matched-filter despreader in the 802.11b 1 Mbps receive chain. It consumes the correlator's per-sample I/Q output and acquires the correlation-peak sample phase over several symbol periods. Once locked, it emits one despread I/Q symbol per symbol period to the DBPSK demodulator. It detects loss of lock and re-acquires autonomously; optional early/late tracking follows slow clock drift.

## Interface
- `DATA_W`, 32: width of the signed despread I/Q inputs and symbol outputs.
- `SPS`, 22: samples per symbol. Range 4..64.
- `ACQ_SYMBOLS`, 4: number of symbol periods in the acquisition window.
- `LOCK_THRESH`, 20000: unsigned magnitude a peak must reach (>=) to count as a hit.
- `LOSS_COUNT`, 8: number of consecutive on-phase misses that drops lock.
- `TRK_LIMIT`, 4: early/late vote count that triggers a phase adjust (only when `SYNC_TRACK_EN` is defined).

- `clk`, input, 1: single clock. All state is on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: run control. When low, the block goes to IDLE synchronously.
- `despread_sample_i`, input, DATA_W: signed correlator I output.
- `despread_sample_q`, input, DATA_W: signed correlator Q output.
- `despread_sample_valid`, input, 1: input sample strobe. At most one sample per cycle.
- `symbol_i`, output, DATA_W: on-time I sample. Holds its value between strobes.
- `symbol_q`, output, DATA_W: on-time Q sample. Holds its value between strobes.
- `symbol_valid`, output, 1: one-cycle strobe marking a new symbol.
- `locked`, output, 1: high while in TRACK.
- `symbol_phase`, output, 6: current on-time phase, 0..SPS-1.

## Operation
- Magnitude: `mag = |i| + |q|`, unsigned, DATA_W+1 bits. `|i|` of the most-negative value equals 2^(DATA_W-1) exactly; no saturation is needed.
- Phase counter `pc`:
  - Counts 0..SPS-1 and wraps to 0.
  - Advances only on valid samples.
  - Cleared in IDLE. The first valid sample after leaving IDLE is phase 0.
- States:
  - **IDLE**: all counters are cleared and `locked`=0. Go to ACQUIRE on the cycle `enable`=1 is sampled.
  - **ACQUIRE**:
    - Over ACQ_SYMBOLS*SPS valid samples, keep `peak_mag` and `peak_phase`.
    - Update only on strict `mag > peak_mag`, so on a tie the earliest sample wins.
    - On the final sample of the window:
      - If `peak_mag >= LOCK_THRESH`: set `symbol_phase = peak_phase` and go to TRACK.
      - Otherwise clear the peak and window count and stay in ACQUIRE. The next window starts with the next sample; `pc` keeps running.
  - **TRACK**:
    - On each valid sample with `pc == symbol_phase`, register I/Q into `symbol_i`/`symbol_q` and pulse `symbol_valid`.
    - A hit (`mag >= LOCK_THRESH`) clears the miss counter. A miss increments it.
    - When the miss counter reaches LOSS_COUNT, go to ACQUIRE. The symbol that caused the loss is still emitted. Peak, window and miss counters are cleared.
- `enable` deasserted in any state goes to IDLE on the next edge. No further `symbol_valid` pulses occur. `symbol_i`/`symbol_q` keep their last values.

## Timing
- Reset values: `symbol_i`=0, `symbol_q`=0, `symbol_valid`=0, `locked`=0, `symbol_phase`=0. State is IDLE and all counters are 0.
- Latency: `symbol_valid`, `symbol_i` and `symbol_q` update on the clock edge that samples the on-phase input. They are visible one cycle after the input cycle.
- `locked` rises one cycle after the last acquisition-window sample. It falls one cycle after the loss-triggering sample, or one cycle after `enable` is sampled low.
- `despread_sample_valid` may be asserted back-to-back or with gaps. Behaviour depends only on valid samples.
- `reset_n` asserted mid-window or mid-track resets everything immediately. No partial state survives.
- `symbol_phase` changes only on an ACQUIRE→TRACK transition or on a tracking adjust.

## Configuration
- `SYNC_TRACK_EN` defined (early/late tracking is compiled in):
  - In TRACK, latch `mag` at phase `(symbol_phase-1) mod SPS` as early and at `(symbol_phase+1) mod SPS` as late.
  - At the late sample, a signed vote counter gets +1 if late>early, −1 if early>late, and no change on a tie.
  - At +TRK_LIMIT: `symbol_phase` = `(symbol_phase+1) mod SPS`. At −TRK_LIMIT: `symbol_phase` = `(symbol_phase−1) mod SPS`. In both cases the counter clears.
  - The adjust takes effect for the next symbol.
  - The vote counter clears on leaving TRACK.
- `SYNC_TRACK_EN` not defined: `symbol_phase` stays fixed between acquisitions. No early/late registers are present.

## Test plan
- Reset/idle: hold `reset_n`=0, then `enable`=0 with valid samples applied → all outputs stay 0 and no `symbol_valid` pulse occurs.
- Acquisition: defaults; I=30000 at phase 7, I=100 elsewhere, Q=0 → `locked` rises one cycle after sample 88. `symbol_phase`=7. Then `symbol_valid` fires every 22 samples with `symbol_i`=30000.
- Threshold fail and tie: peak 19999 for one window, then two equal peaks of 25000 at phases 3 and 9 → no lock after window 1; lock with phase 3 after window 2.
- Loss of lock: after lock, drop all magnitudes to 100 → 8 more `symbol_valid` pulses, then `locked`=0 one cycle after the 8th. A restored peak re-locks one window later.
- Gapped valid and enable drop: valid at 1 in 3 cycles → same symbol sequence as the back-to-back case. `enable`=0 mid-track → `locked`=0 next cycle and no further strobes.
- With `SYNC_TRACK_EN`: lock at phase 7, then make phase 8 > phase 6 for 4 symbols → `symbol_phase`=8 after the 4th late sample. The next strobe comes 23 samples after the previous one.

Source files
------------

// File: rtl/despread_symbol_sync.sv
// rtl/despread_symbol_sync.sv - Barker despreader symbol-timing acquisition, lock and tracking
//
// Optional feature macro: SYNC_TRACK_EN (early/late phase tracking of slow clock drift).
//
// Ports:
//   clk                    single clock, rising edge
//   reset_n                asynchronous active-low reset
//   enable                 run control; low returns to IDLE on the next edge
//   despread_sample_i/q    signed correlator I/Q samples (DATA_W)
//   despread_sample_valid  input sample strobe
//   symbol_i/q             on-time I/Q, held between strobes
//   symbol_valid           one-cycle strobe per emitted symbol
//   locked                 high while tracking
//   symbol_phase           current on-time phase, 0..SPS-1
module despread_symbol_sync #(
    parameter int DATA_W      = 32,
    parameter int SPS         = 22,
    parameter int ACQ_SYMBOLS = 4,
    parameter int LOCK_THRESH = 20000,
    parameter int LOSS_COUNT  = 8,
    parameter int TRK_LIMIT   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] despread_sample_i,
    input  logic [DATA_W-1:0] despread_sample_q,
    input  logic              despread_sample_valid,
    output logic [DATA_W-1:0] symbol_i,
    output logic [DATA_W-1:0] symbol_q,
    output logic              symbol_valid,
    output logic              locked,
    output logic [5:0]        symbol_phase
);

    localparam int ACQ_LEN = ACQ_SYMBOLS * SPS;
    localparam int WIN_W   = $clog2(ACQ_LEN + 1);
    localparam int MISS_W  = $clog2(LOSS_COUNT + 1);

    localparam logic [5:0]        C_SPS_M1    = 6'(SPS - 1);
    localparam logic [DATA_W:0]   C_THRESH    = (DATA_W + 1)'(LOCK_THRESH);
    localparam logic [DATA_W:0]   C_ONE_MAG   = (DATA_W + 1)'(1);
    localparam logic [WIN_W-1:0]  C_WIN_LAST  = WIN_W'(ACQ_LEN - 1);
    localparam logic [MISS_W-1:0] C_MISS_LAST = MISS_W'(LOSS_COUNT - 1);

    if (SPS < 4 || SPS > 64 || TRK_LIMIT < 1 || LOSS_COUNT < 1) begin : g_param_check
        $error("despread_symbol_sync: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACQUIRE = 2'd1,
        S_TRACK   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [5:0]          r_pc;
    logic [WIN_W-1:0]    r_win_cnt;
    logic [DATA_W:0]     r_peak_mag;
    logic [5:0]          r_peak_phase;
    logic [MISS_W-1:0]   r_miss_cnt;
    logic [5:0]          r_symbol_phase;
    logic [DATA_W-1:0]   r_symbol_i;
    logic [DATA_W-1:0]   r_symbol_q;
    logic                r_symbol_valid;

    logic [DATA_W:0]     w_ext_i;
    logic [DATA_W:0]     w_ext_q;
    logic [DATA_W:0]     w_abs_i;
    logic [DATA_W:0]     w_abs_q;
    logic [DATA_W:0]     w_mag;
    logic [DATA_W:0]     w_cand_mag;
    logic [5:0]          w_cand_phase;
    logic [5:0]          w_pc_next;
    logic                w_win_last;
    logic                w_acq_hit;
    logic                w_hit;
    logic                w_on_time;
    logic                w_miss_last;

    // Sign-extend by one bit before negating so the most-negative input
    // yields exactly 2^(DATA_W-1); the sum of two such values still fits.
    assign w_ext_i = {despread_sample_i[DATA_W-1], despread_sample_i};
    assign w_ext_q = {despread_sample_q[DATA_W-1], despread_sample_q};
    assign w_abs_i = w_ext_i[DATA_W] ? (~w_ext_i + C_ONE_MAG) : w_ext_i;
    assign w_abs_q = w_ext_q[DATA_W] ? (~w_ext_q + C_ONE_MAG) : w_ext_q;
    assign w_mag   = w_abs_i + w_abs_q;

    // Strict greater-than keeps the earliest sample on a tie.
    assign w_cand_mag   = (w_mag > r_peak_mag) ? w_mag : r_peak_mag;
    assign w_cand_phase = (w_mag > r_peak_mag) ? r_pc  : r_peak_phase;

    assign w_pc_next   = (r_pc == C_SPS_M1) ? 6'd0 : r_pc + 6'd1;
    assign w_win_last  = (r_win_cnt == C_WIN_LAST);
    assign w_acq_hit   = (w_cand_mag >= C_THRESH);
    assign w_hit       = (w_mag >= C_THRESH);
    assign w_on_time   = (r_pc == r_symbol_phase);
    assign w_miss_last = !w_hit && (r_miss_cnt == C_MISS_LAST);

`ifdef SYNC_TRACK_EN
    localparam int VOTE_W = $clog2(TRK_LIMIT + 1) + 1;
    localparam logic signed [VOTE_W-1:0] C_VOTE_POS = VOTE_W'(TRK_LIMIT);
    localparam logic signed [VOTE_W-1:0] C_VOTE_NEG = -C_VOTE_POS;
    localparam logic signed [VOTE_W-1:0] C_VOTE_ONE = VOTE_W'(1);

    logic [DATA_W:0]            r_early_mag;
    logic                       r_early_vld;
    logic signed [VOTE_W-1:0]   r_vote;
    logic [5:0]                 w_phase_inc;
    logic [5:0]                 w_phase_dec;
    logic signed [VOTE_W-1:0]   w_vote_next;

    // Early sits one phase before on-time, late one phase after (mod SPS).
    assign w_phase_inc = (r_symbol_phase == C_SPS_M1) ? 6'd0 : r_symbol_phase + 6'd1;
    assign w_phase_dec = (r_symbol_phase == 6'd0) ? C_SPS_M1 : r_symbol_phase - 6'd1;

    always_comb begin
        w_vote_next = r_vote;
        if (w_mag > r_early_mag) begin
            w_vote_next = r_vote + C_VOTE_ONE;
        end else if (w_mag < r_early_mag) begin
            w_vote_next = r_vote - C_VOTE_ONE;
        end
    end
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        if (!enable) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    w_next_state = S_ACQUIRE;
                S_ACQUIRE: if (despread_sample_valid && w_win_last && w_acq_hit)
                               w_next_state = S_TRACK;
                S_TRACK:   if (despread_sample_valid && w_on_time && w_miss_last)
                               w_next_state = S_ACQUIRE;
                default:   w_next_state = S_IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        locked = (r_state == S_TRACK);
    end

    // Counters, peak search, symbol capture and optional phase tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc           <= 6'd0;
            r_win_cnt      <= '0;
            r_peak_mag     <= '0;
            r_peak_phase   <= 6'd0;
            r_miss_cnt     <= '0;
            r_symbol_phase <= 6'd0;
            r_symbol_i     <= '0;
            r_symbol_q     <= '0;
            r_symbol_valid <= 1'b0;
`ifdef SYNC_TRACK_EN
            r_early_mag    <= '0;
            r_early_vld    <= 1'b0;
            r_vote         <= '0;
`endif
        end else begin
            r_symbol_valid <= 1'b0;
            if (!enable || r_state == S_IDLE) begin
                r_pc         <= 6'd0;
                r_win_cnt    <= '0;
                r_peak_mag   <= '0;
                r_peak_phase <= 6'd0;
                r_miss_cnt   <= '0;
`ifdef SYNC_TRACK_EN
                r_early_vld  <= 1'b0;
                r_vote       <= '0;
`endif
            end else if (despread_sample_valid) begin
                r_pc <= w_pc_next;
                if (r_state == S_ACQUIRE) begin
                    if (w_win_last) begin
                        // Window closes: either lock or start a fresh window
                        // with the next sample while pc keeps running.
                        r_win_cnt    <= '0;
                        r_peak_mag   <= '0;
                        r_peak_phase <= 6'd0;
                        r_miss_cnt   <= '0;
                        if (w_acq_hit) begin
                            r_symbol_phase <= w_cand_phase;
                        end
                    end else begin
                        r_win_cnt    <= r_win_cnt + WIN_W'(1);
                        r_peak_mag   <= w_cand_mag;
                        r_peak_phase <= w_cand_phase;
                    end
                end else if (r_state == S_TRACK) begin
                    if (w_on_time) begin
                        r_symbol_i     <= despread_sample_i;
                        r_symbol_q     <= despread_sample_q;
                        r_symbol_valid <= 1'b1;
                        if (w_hit) begin
                            r_miss_cnt <= '0;
                        end else if (w_miss_last) begin
                            r_miss_cnt  <= '0;
`ifdef SYNC_TRACK_EN
                            r_early_vld <= 1'b0;
                            r_vote      <= '0;
`endif
                        end else begin
                            r_miss_cnt <= r_miss_cnt + MISS_W'(1);
                        end
                    end
`ifdef SYNC_TRACK_EN
                    if (r_pc == w_phase_dec) begin
                        r_early_mag <= w_mag;
                        r_early_vld <= 1'b1;
                    end
                    // Vote only against an early sample taken for the current
                    // phase; a stale one after lock or adjust would bias it.
                    if (r_pc == w_phase_inc && r_early_vld) begin
                        r_early_vld <= 1'b0;
                        if (w_vote_next == C_VOTE_POS) begin
                            r_symbol_phase <= w_phase_inc;
                            r_vote         <= '0;
                        end else if (w_vote_next == C_VOTE_NEG) begin
                            r_symbol_phase <= w_phase_dec;
                            r_vote         <= '0;
                        end else begin
                            r_vote <= w_vote_next;
                        end
                    end
`endif
                end
            end
        end
    end

    assign symbol_i     = r_symbol_i;
    assign symbol_q     = r_symbol_q;
    assign symbol_valid = r_symbol_valid;
    assign symbol_phase = r_symbol_phase;

endmodule

// File: tb/tb_despread_symbol_sync.sv
// tb/tb_despread_symbol_sync.sv - scoreboard bench for despread_symbol_sync
module tb_despread_symbol_sync;

    localparam int SPS = 22;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [31:0] s_i;
    logic [31:0] s_q;
    logic        valid;
    logic [31:0] symbol_i;
    logic [31:0] symbol_q;
    logic        symbol_valid;
    logic        locked;
    logic [5:0]  symbol_phase;

    despread_symbol_sync dut (
        .clk                   (clk),
        .reset_n               (reset_n),
        .enable                (enable),
        .despread_sample_i     (s_i),
        .despread_sample_q     (s_q),
        .despread_sample_valid (valid),
        .symbol_i              (symbol_i),
        .symbol_q              (symbol_q),
        .symbol_valid          (symbol_valid),
        .locked                (locked),
        .symbol_phase          (symbol_phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] i;
        logic [31:0] q;
        logic        lk;
        logic [5:0]  ph;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    int   checks = 0;
    int   errors = 0;
    int   tb_pc;
    int   exp_on;
    int   gap;
    logic exp_lock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest expected symbol.
    always @(negedge clk) begin
        if (symbol_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe actual i=%0d phase=%0d required no strobe",
                         $signed(symbol_i), symbol_phase);
            end else begin
                m_e = exp_q.pop_front();
                if (symbol_i !== m_e.i || symbol_q !== m_e.q ||
                    locked !== m_e.lk || symbol_phase !== m_e.ph) begin
                    errors++;
                    $display("FAIL symbol actual i=%0d q=%0d lock=%0b ph=%0d required i=%0d q=%0d lock=%0b ph=%0d",
                             $signed(symbol_i), $signed(symbol_q), locked, symbol_phase,
                             $signed(m_e.i), $signed(m_e.q), m_e.lk, m_e.ph);
                end
            end
        end
    end

    task automatic send_sample(input logic [31:0] vi, input logic [31:0] vq);
        if (exp_on >= 0 && tb_pc == exp_on)
            exp_q.push_back('{vi, vq, exp_lock, 6'(exp_on)});
        s_i   = vi;
        s_q   = vq;
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
        tb_pc = (tb_pc == SPS - 1) ? 0 : tb_pc + 1;
    endtask

    task automatic send_n(input int n, input int p1, input int p2, input logic [31:0] pv,
                          input logic [31:0] base, input logic [31:0] pq);
        for (int k = 0; k < n; k++) begin
            if (tb_pc == p1 || tb_pc == p2) send_sample(pv, pq);
            else send_sample(base, 32'd0);
        end
    endtask

`ifdef SYNC_TRACK_EN
    task automatic send_prof(input int n, input int ph, input logic [31:0] ve,
                             input logic [31:0] vo, input logic [31:0] vl);
        for (int k = 0; k < n; k++) begin
            if (tb_pc == ph - 1) send_sample(ve, 32'd0);
            else if (tb_pc == ph) send_sample(vo, 32'd0);
            else if (tb_pc == ph + 1) send_sample(vl, 32'd0);
            else send_sample(32'd100, 32'd0);
        end
    endtask
`endif

    task automatic restart();
        enable = 1'b0;
        @(posedge clk); #1;
        enable = 1'b1;
        @(posedge clk); #1;
        tb_pc = 0;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b0; valid = 1'b0; s_i = '0; s_q = '0;
        gap = 0; exp_on = -1; exp_lock = 1'b0; tb_pc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_symbol_i", symbol_i, 0);
        chk("rst_symbol_q", symbol_q, 0);
        chk("rst_symbol_valid", symbol_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_phase", symbol_phase, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Disabled: samples with strong peaks must produce nothing.
        send_n(100, 7, 7, 32'd30000, 32'd100, 32'd0);
        chk("idle_locked", locked, 0);
        chk("idle_symbol_i", symbol_i, 0);

        // Window 1 peaks at 19999 (below threshold); window 2 ties at 3 and 9.
        restart();
        send_n(88, 7, 7, 32'd19999, 32'd100, 32'd0);
        chk("thresh_nolock", locked, 0);
        send_n(88, 3, 9, 32'd25000, 32'd100, 32'd0);
        chk("tie_locked", locked, 1);
        chk("tie_phase", symbol_phase, 3);
        exp_on = 3; exp_lock = 1'b1;
        send_n(22, 3, 9, 32'd25000, 32'd100, 32'd0);

        // Enable drop in TRACK: unlock next cycle, outputs hold.
        enable = 1'b0;
        @(posedge clk); #1;
        chk("endrop_locked", locked, 0);
        exp_on = -1;
        send_n(22, 3, 9, 32'd25000, 32'd100, 32'd0);
        chk("endrop_hold_i", symbol_i, 25000);

        // Default acquisition: lock visible one cycle after sample 88.
        restart();
        send_n(87, 7, 7, 32'd30000, 32'd100, 32'd0);
        chk("acq_prelock", locked, 0);
        send_n(1, 7, 7, 32'd30000, 32'd100, 32'd0);
        chk("acq_locked", locked, 1);
        chk("acq_phase", symbol_phase, 7);
        exp_on = 7; exp_lock = 1'b1;
        send_n(44, 7, 7, 32'd30000, 32'd100, 32'd0);
        send_n(22, 7, 7, -32'sd15000, 32'd100, -32'sd15000);

        // Loss of lock: 8 missed on-time samples, the 8th strobe sees unlock.
        for (int m = 1; m <= 8; m++) begin
            exp_lock = (m < 8);
            send_n(22, -1, -1, 32'd0, 32'd100, 32'd0);
            if (m == 7) chk("loss_still_locked", locked, 1);
        end
        chk("loss_unlocked", locked, 0);
        exp_on = -1;
        send_n(73, 7, 7, 32'd30000, 32'd100, 32'd0);
        chk("relock_pre", locked, 0);
        send_n(1, 7, 7, 32'd30000, 32'd100, 32'd0);
        chk("relock_locked", locked, 1);
        chk("relock_phase", symbol_phase, 7);
        exp_on = 7; exp_lock = 1'b1;
        send_n(36, 7, 7, 32'd30000, 32'd100, 32'd0);

        // Gapped valid: one sample every third cycle.
        gap = 2;
        restart();
        exp_on = -1;
        send_n(88, 7, 7, 32'd30000, 32'd100, 32'd0);
        chk("gap_locked", locked, 1);
        chk("gap_phase", symbol_phase, 7);
        exp_on = 7;
        send_n(44, 7, 7, 32'd30000, 32'd100, 32'd0);
        send_n(10, 7, 7, 32'd30000, 32'd100, 32'd0);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("gap_endrop_locked", locked, 0);
        exp_on = -1;
        send_n(12, 7, 7, 32'd30000, 32'd100, 32'd0);
        gap = 0;

        // Reset mid-window: no partial window may survive.
        restart();
        send_n(40, 7, 7, 32'd30000, 32'd100, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_symbol_i", symbol_i, 0);
        chk("midrst_locked", locked, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        restart();
        send_n(87, 7, 7, 32'd30000, 32'd100, 32'd0);
        chk("midrst_no_partial", locked, 0);
        send_n(1, 7, 7, 32'd30000, 32'd100, 32'd0);
        chk("midrst_relock", locked, 1);

        // Reset mid-track.
        send_n(3, 7, 7, 32'd30000, 32'd100, 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("trkrst_locked", locked, 0);
        chk("trkrst_phase", symbol_phase, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;

`ifdef SYNC_TRACK_EN
        // Late (phase 8) stronger than early (phase 6) for 4 symbols.
        restart();
        exp_on = -1;
        send_prof(88, 7, 32'd5000, 32'd30000, 32'd10000);
        chk("trk_lock_phase", symbol_phase, 7);
        exp_on = 7; exp_lock = 1'b1;
        for (int p = 1; p <= 4; p++) begin
            send_prof(22, 7, 32'd5000, 32'd30000, 32'd10000);
            if (p == 3) chk("trk_phase_p3", symbol_phase, 7);
        end
        chk("trk_phase_adjusted", symbol_phase, 8);
        exp_on = 8;
        send_prof(22, 7, 32'd5000, 32'd30000, 32'd10000);
`endif

        enable = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
